// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types
// Description : Shared types for the load/store unit memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } lsu_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } memfn_t;

    // sdata holds the already lane-replicated store data.
    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] ea;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] pc;
    } lsu_req_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering, store replication, access legality and
//               load extraction/extension for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import rv32i_types::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_ea_lo,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_enable,
    output logic [31:0] o_wdata,
    output logic        o_exc,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shifted;
    logic        w_illegal;
    logic        w_misaligned;

    always_comb begin
        o_byte_enable = 4'b1111;
        o_wdata       = i_sdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_byte_enable = 4'b0001 << i_ea_lo;
                o_wdata       = {4{i_sdata[7:0]}};
            end
            2'b01: begin
                o_byte_enable = 4'b0011 << i_ea_lo;
                o_wdata       = {2{i_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_illegal    = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                       (i_is_store && i_funct3[2]);
        w_misaligned = ALIGN_CHECK &&
                       (((i_funct3[1:0] == 2'b01) && i_ea_lo[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_ea_lo != 2'b00)));
        o_exc        = w_illegal || w_misaligned;
    end

    always_comb begin
        w_shifted = i_rdata >> {i_ea_lo, 3'b000};
        o_ldata   = 32'd0;
        case (i_funct3)
            lb:      o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            lh:      o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            lw:      o_ldata = w_shifted;
            lbu:     o_ldata = {24'd0, w_shifted[7:0]};
            lhu:     o_ldata = {16'd0, w_shifted[15:0]};
            default: o_ldata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : Single-outstanding load/store unit between the memory issue
//               queue and the data-memory port, returning results to WB.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import rv32i_types::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_sdata,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_has_rd,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exc,
    output logic [31:0] wb_pc
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    lsu_req_t    r_req;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [3:0]  r_be;
    logic        r_kill;
    logic        r_wb_has_rd;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;
    logic [31:0] r_wb_pc;

    logic        w_idle;
    logic        w_accept;
    logic [31:0] w_ea;
    logic [2:0]  w_fn;
    logic        w_st;
    logic [1:0]  w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_exc;
    logic [31:0] w_ldata;
    logic        w_drop_load;

    assign w_idle      = (r_state == IDLE);
    assign in_ready    = w_idle && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_ea        = in_base + in_imm;
    assign w_drop_load = !r_req.is_store && (flush || r_kill);

    // Aligner sees the incoming uop while idle, the held request otherwise.
    assign w_fn = w_idle ? in_funct3   : r_req.funct3;
    assign w_st = w_idle ? in_is_store : r_req.is_store;
    assign w_lo = w_idle ? w_ea[1:0]   : r_req.ea[1:0];

    lsu_align #(
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_align (
        .i_is_store    (w_st),
        .i_funct3      (w_fn),
        .i_ea_lo       (w_lo),
        .i_sdata       (in_sdata),
        .i_rdata       (mem_rdata),
        .o_byte_enable (w_be),
        .o_wdata       (w_wdata),
        .o_exc         (w_exc),
        .o_ldata       (w_ldata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_exc ? WB : MEM;
            MEM:  if (mem_resp) w_state_nxt = w_drop_load ? IDLE : WB;
            WB:   if (wb_ready || (flush && !r_req.is_store)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_be        <= 4'd0;
            r_kill      <= 1'b0;
            r_wb_has_rd <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_exc    <= 1'b0;
            r_wb_pc     <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req  <= '{is_store: in_is_store, funct3: in_funct3,
                                    ea: w_ea, sdata: w_wdata, rd: in_rd, pc: in_pc};
                        r_kill <= 1'b0;
                        if (w_exc) begin
                            r_wb_exc    <= 1'b1;
                            r_wb_has_rd <= 1'b0;
                            r_wb_data   <= 32'd0;
                            r_wb_rd     <= in_rd;
                            r_wb_pc     <= in_pc;
                        end else begin
                            r_mem_read  <= !in_is_store;
                            r_mem_write <= in_is_store;
                            r_be        <= w_be;
                        end
                    end
                end
                MEM: begin
                    // A flushed load must still see its response before leaving.
                    if (flush && !r_req.is_store) r_kill <= 1'b1;
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_wb_exc    <= 1'b0;
                        r_wb_has_rd <= !r_req.is_store;
                        r_wb_data   <= r_req.is_store ? 32'd0 : w_ldata;
                        r_wb_rd     <= r_req.rd;
                        r_wb_pc     <= r_req.pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_address     = {r_req.ea[31:2], 2'b00};
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_be;
    assign mem_wdata       = r_req.sdata;
    assign wb_valid        = (r_state == WB);
    assign wb_has_rd       = r_wb_has_rd;
    assign wb_rd           = r_wb_rd;
    assign wb_data         = r_wb_data;
    assign wb_exc          = r_wb_exc;
    assign wb_pc           = r_wb_pc;

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Single-outstanding load/store unit that sits directly downstream of the memory issue queue. It consumes one popped memory uop per handshake, computes the effective address, and drives the CPU data-memory port (mem_address/mem_read/mem_write/mem_byte_enable) until mem_resp. It then returns aligned, extended load data (or store completion) to writeback. It replaces the current tie-off on the memory queue output.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned half/word access raises wb_exc and skips memory; 0 = access issued with low address bits ignored

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  memory uop available from memory queue
in_ready  out  1  unit can accept a uop this cycle
in_is_store  in  1  1 = store, 0 = load
in_funct3  in  3  RV32I funct3 (size/sign)
in_base  in  32  rs1 value
in_imm  in  32  sign-extended I/S immediate
in_sdata  in  32  rs2 value (stores)
in_rd  in  5  destination register (loads)
in_pc  in  32  uop pc, returned with exception
flush  in  1  kill speculative load in flight
mem_address  out  32  word-aligned address
mem_read  out  1  read request
mem_write  out  1  write request
mem_byte_enable  out  4  byte lanes
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  load data, valid with mem_resp
mem_resp  in  1  memory completion
wb_valid  out  1  result/completion available
wb_ready  in  1  writeback accepts
wb_has_rd  out  1  1 for loads
wb_rd  out  5  destination
wb_data  out  32  extended load data; 0 for stores
wb_exc  out  1  misaligned or illegal funct3
wb_pc  out  32  pc of completing uop

Behaviour:
- FSM states IDLE, MEM, WB. After reset: IDLE; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, wb_valid=0, wb_has_rd=0, wb_rd=0, wb_data=0, wb_exc=0, wb_pc=0, in_ready=1.
- in_ready = (state==IDLE) & !flush. Accept when in_valid & in_ready.
- On accept: ea = in_base + in_imm, mod 2^32. mem_address <= {ea[31:2],2'b00}. Byte enables: byte -> 4'b0001<<ea[1:0]; half -> 4'b0011<<ea[1:0]; word -> 4'b1111. mem_wdata: byte = {4{sdata[7:0]}}, half = {2{sdata[15:0]}}, word = sdata.
- Exception cases: funct3 in {011,110,111}; store funct3 >=100; or, if ALIGN_CHECK=1, half with ea[0]=1 or word with ea[1:0]!=0. Any of these -> go directly to WB with wb_exc=1, wb_has_rd=0, and no memory request.
- Otherwise -> MEM. All memory outputs are registered: mem_read (load) or mem_write (store) is high from cycle N+1 (accept at N) through the cycle mem_resp is sampled high, then clears on the next edge. Address, data and byte enables are held stable throughout MEM.
- On mem_resp in MEM: for loads, the data is mem_rdata >> (8*ea[1:0]), then lb/lh sign-extend bit 7/15, lbu/lhu zero-extend, lw passes through. This value is registered into wb_data. Next state WB. Best case: accept at N, resp at N+1, wb_valid at N+2.
- WB: wb_valid=1; wb_rd, wb_data, wb_exc and wb_pc are held until wb_ready, then IDLE. A new uop is accepted no earlier than the cycle after the WB handshake.
- flush handling:
  - IDLE: blocks acceptance only.
  - MEM with a load: the request is held until mem_resp (the memory handshake is never abandoned), the result is discarded, and the FSM returns to IDLE with no wb_valid.
  - MEM or WB with a store: ignored, because stores issue non-speculatively.
  - WB with a load: wb_valid drops the next cycle and the FSM returns to IDLE.
  - flush in the same cycle as mem_resp: the result is discarded.
- mem_resp outside MEM: ignored.
- Reset mid-operation: asynchronous return to IDLE. mem_read and mem_write deassert immediately, and all outputs take their reset values.

Decomposition:
- rv32i_types package gets:
  - lsu_state_t enum (IDLE, MEM, WB)
  - memfn constants: lb=000, lh=001, lw=010, lbu=100, lhu=101
  - lsu_req_t struct (is_store, funct3, ea, sdata, rd, pc)
- One combinational sub-module, lsu_align: from funct3, ea[1:0] and sdata it generates byte_enable, replicated wdata and the exception flag; from funct3, ea[1:0] and rdata it produces the extended load data.
- The FSM and registers stay in lsu_mem_stage.

Test Plan:
- lw, base=0x1000, imm=4; mem_resp one cycle after mem_read with rdata=0xDEADBEEF -> mem_address=0x1004, be=1111, wb_data=0xDEADBEEF, wb_rd matches, wb_valid at accept+2.
- lb/lbu at ea=0x2003, rdata=0x80112233 -> be=1000; lb gives 0xFFFFFF80, lbu gives 0x00000080.
- sh, sdata=0x0000ABCD, ea=0x3002, mem_resp delayed 5 cycles -> mem_write held 5 cycles, be=1100, wdata=0xABCDABCD; wb_has_rd=0, wb_data=0.
- lw at ea=0x4002 with ALIGN_CHECK=1 -> no mem_read ever, wb_exc=1, wb_pc=in_pc; same with funct3=011.
- Load in MEM, flush pulsed, mem_resp 3 cycles later -> mem_read held until resp, no wb_valid, in_ready=1 next cycle; wb_ready=0 for 4 cycles in WB -> outputs stable, no new accept.
- rst asserted mid-MEM -> mem_read=0 immediately, in_ready=1 after release, next lw completes normally.
